// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: FSM states,
// forward-select encoding and the per-stage latch control bundle.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_WAIT = 3'd1,
        LU_STALL = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic xmem;
        logic wb;
    } stage_ctl_t;

    // The producer in EX is younger than the one in MEM, so its result wins.
    function automatic fwd_sel_t fwd_pick(input logic ex_match, input logic mem_match);
        fwd_sel_t sel;
        if (ex_match) begin
            sel = FWD_MEM;
        end else if (mem_match) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/producer info in,
// latch stall/flush, PC enable, forward selects and perf counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_halt;
    logic [REGW-1:0] ex_wsel;
    logic            ex_regwr;
    logic            ex_load;
    logic [REGW-1:0] mem_wsel;
    logic            mem_regwr;
    logic            dmem_req;
    logic            dhit;
    logic            ihit;
    logic            redirect;
    logic            halt_wb;

    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;
    logic            stall_ifid;
    logic            stall_idex;
    logic            stall_xmem;
    logic            stall_wb;
    logic            flush_ifid;
    logic            flush_idex;
    logic            flush_xmem;
    logic            flush_wb;
    logic            pc_en;
    logic            halted;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
               ex_wsel, ex_regwr, ex_load, mem_wsel, mem_regwr,
               dmem_req, dhit, ihit, redirect, halt_wb,
        input  fwd_a, fwd_b, stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb,
               pc_en, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
               ex_wsel, ex_regwr, ex_load, mem_wsel, mem_regwr,
               dmem_req, dhit, ihit, redirect, halt_wb,
        output fwd_a, fwd_b, stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb,
               pc_en, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_predecode.sv
// Forward-select predecode: compares both ID source registers against the EX and
// MEM producers and registers the selects for use when the instruction is in EX.
module pipeline_hazard_ctrl_fwd_predecode
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] ex_wsel,
    input  logic            ex_regwr,
    input  logic [REGW-1:0] mem_wsel,
    input  logic            mem_regwr,
    input  logic            stall_idex,
    input  logic            flush_idex,
    output fwd_sel_t        fwd_a,
    output fwd_sel_t        fwd_b
);

    logic [1:0][REGW-1:0] id_src_s;
    logic [1:0]           ex_match_s;
    logic [1:0]           mem_match_s;
    fwd_sel_t [1:0]       sel_d;
    fwd_sel_t [1:0]       sel_q;

    assign id_src_s = {id_rt, id_rs};

    // Source compare and select update; a flush beats a stall and r0 never forwards.
    always_comb begin
        ex_match_s  = 2'b00;
        mem_match_s = 2'b00;
        sel_d       = sel_q;
        for (int i = 0; i < 2; i++) begin
            ex_match_s[i]  = ex_regwr  && (ex_wsel  != '0) && (ex_wsel  == id_src_s[i]);
            mem_match_s[i] = mem_regwr && (mem_wsel != '0) && (mem_wsel == id_src_s[i]);
        end
        if (flush_idex) begin
            sel_d = {FWD_NONE, FWD_NONE};
        end else if (stall_idex) begin
            sel_d = sel_q;
        end else begin
            sel_d = {fwd_pick(ex_match_s[1], mem_match_s[1]),
                     fwd_pick(ex_match_s[0], mem_match_s[0])};
        end
    end

    // Select register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q <= {FWD_NONE, FWD_NONE};
        end else begin
            sel_q <= sel_d;
        end
    end

    assign fwd_a = sel_q[0];
    assign fwd_b = sel_q[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller top: stall FSM (dcache miss, load-use bubbles, halt drain),
// branch redirect flushing, forward predecode and saturating perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REGW       = 5,
    parameter int BRANCH_STG = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CNTW       = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] LU_MAX = 2'(LU_BUBBLES);

    hz_state_t       state_q, state_d;
    hz_state_t       ret_q, ret_d;
    hz_state_t       eff_state_s;
    logic [1:0]      lu_cnt_q, lu_cnt_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
    logic            miss_s;
    logic            lu_hit_s;
    stage_ctl_t      stall_s;
    stage_ctl_t      flush_s;
    logic            pc_en_s;

    assign miss_s   = hz.dmem_req && !hz.dhit;
    assign lu_hit_s = hz.ex_load && hz.ex_regwr && (hz.ex_wsel != '0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_wsel)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_wsel)));
    // Leaving MEM_WAIT, the held state acts in the same cycle the latches advance.
    assign eff_state_s = (state_q == MEM_WAIT) ? ret_q : state_q;

    // State, return-state, bubble count and counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            lu_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic, priority halt_wb > miss > load-use > drain > redirect.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        lu_cnt_d = lu_cnt_q;
        if ((state_q == HALTED) || hz.halt_wb) begin
            state_d = HALTED;
        end else if (miss_s) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end else begin
                ret_d = ret_q;
            end
        end else begin
            case (eff_state_s)
                LU_STALL: begin
                    if ((lu_cnt_q + 2'd1) >= LU_MAX) begin
                        state_d  = RUN;
                        lu_cnt_d = 2'd0;
                    end else begin
                        state_d  = LU_STALL;
                        lu_cnt_d = lu_cnt_q + 2'd1;
                    end
                end
                DRAIN: state_d = DRAIN;
                RUN: begin
                    if (lu_hit_s) begin
                        if (LU_MAX > 2'd1) begin
                            state_d  = LU_STALL;
                            lu_cnt_d = 2'd1;
                        end else begin
                            state_d  = RUN;
                            lu_cnt_d = 2'd0;
                        end
                    end else if (hz.id_halt) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Latch stall/flush and PC enable for the current cycle.
    always_comb begin
        stall_s = '0;
        flush_s = '0;
        pc_en_s = 1'b0;
        if ((state_q == HALTED) || hz.halt_wb) begin
            stall_s = '1;
        end else if (miss_s) begin
            stall_s.ifid = 1'b1;
            stall_s.idex = 1'b1;
            stall_s.xmem = 1'b1;
            flush_s.wb   = 1'b1;
        end else begin
            case (eff_state_s)
                LU_STALL: begin
                    stall_s.ifid = 1'b1;
                    flush_s.idex = 1'b1;
                end
                DRAIN: flush_s.ifid = 1'b1;
                RUN: begin
                    if (lu_hit_s) begin
                        stall_s.ifid = 1'b1;
                        flush_s.idex = 1'b1;
                    end else if (hz.id_halt) begin
                        flush_s.ifid = 1'b1;
                    end else if (hz.redirect) begin
                        pc_en_s      = 1'b1;
                        flush_s.ifid = 1'b1;
                        flush_s.idex = (BRANCH_STG == 2);
                    end else begin
                        pc_en_s      = hz.ihit;
                        flush_s.ifid = !hz.ihit;
                    end
                end
                default: stall_s = '1;
            endcase
        end
    end

    // Saturating perf counters.
    always_comb begin
        if ((stall_s != '0) && (state_q != HALTED) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if ((flush_s != '0) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNTW'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    pipeline_hazard_ctrl_fwd_predecode #(.REGW(REGW)) u_fwd (
        .CLK        (CLK),
        .RST        (RST),
        .id_rs      (hz.id_rs),
        .id_rt      (hz.id_rt),
        .ex_wsel    (hz.ex_wsel),
        .ex_regwr   (hz.ex_regwr),
        .mem_wsel   (hz.mem_wsel),
        .mem_regwr  (hz.mem_regwr),
        .stall_idex (stall_s.idex),
        .flush_idex (flush_s.idex),
        .fwd_a      (hz.fwd_a),
        .fwd_b      (hz.fwd_b)
    );

    assign hz.stall_ifid = stall_s.ifid;
    assign hz.stall_idex = stall_s.idex;
    assign hz.stall_xmem = stall_s.xmem;
    assign hz.stall_wb   = stall_s.wb;
    assign hz.flush_ifid = flush_s.ifid;
    assign hz.flush_idex = flush_s.idex;
    assign hz.flush_xmem = flush_s.xmem;
    assign hz.flush_wb   = flush_s.wb;
    assign hz.pc_en      = pc_en_s;
    assign hz.halted     = (state_q == HALTED);
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two controllers (EX-resolved branches / 1 bubble / 16-bit counters
// and ID-resolved branches / 2 bubbles / 4-bit counters) share one stimulus stream.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_bad;

    pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(16)) hz0 ();
    pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(4))  hz1 ();

    pipeline_hazard_ctrl #(.REGW(5), .BRANCH_STG(2), .LU_BUBBLES(1), .CNTW(16)) dut0 (
        .CLK (CLK), .RST (RST), .hz (hz0.slave));
    pipeline_hazard_ctrl #(.REGW(5), .BRANCH_STG(1), .LU_BUBBLES(2), .CNTW(4)) dut1 (
        .CLK (CLK), .RST (RST), .hz (hz1.slave));

    assign hz1.id_rs     = hz0.id_rs;
    assign hz1.id_rt     = hz0.id_rt;
    assign hz1.id_use_rs = hz0.id_use_rs;
    assign hz1.id_use_rt = hz0.id_use_rt;
    assign hz1.id_halt   = hz0.id_halt;
    assign hz1.ex_wsel   = hz0.ex_wsel;
    assign hz1.ex_regwr  = hz0.ex_regwr;
    assign hz1.ex_load   = hz0.ex_load;
    assign hz1.mem_wsel  = hz0.mem_wsel;
    assign hz1.mem_regwr = hz0.mem_regwr;
    assign hz1.dmem_req  = hz0.dmem_req;
    assign hz1.dhit      = hz0.dhit;
    assign hz1.ihit      = hz0.ihit;
    assign hz1.redirect  = hz0.redirect;
    assign hz1.halt_wb   = hz0.halt_wb;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stall/flush vectors are {ifid, idex, xmem, wb}.
    task automatic ctl(input string tag,
                       input logic [3:0] st0, input logic [3:0] fl0, input logic pc0,
                       input logic [3:0] st1, input logic [3:0] fl1, input logic pc1);
        check({tag, ".stall0"}, 32'({hz0.stall_ifid, hz0.stall_idex, hz0.stall_xmem, hz0.stall_wb}), 32'(st0));
        check({tag, ".flush0"}, 32'({hz0.flush_ifid, hz0.flush_idex, hz0.flush_xmem, hz0.flush_wb}), 32'(fl0));
        check({tag, ".pc_en0"}, 32'(hz0.pc_en), 32'(pc0));
        check({tag, ".stall1"}, 32'({hz1.stall_ifid, hz1.stall_idex, hz1.stall_xmem, hz1.stall_wb}), 32'(st1));
        check({tag, ".flush1"}, 32'({hz1.flush_ifid, hz1.flush_idex, hz1.flush_xmem, hz1.flush_wb}), 32'(fl1));
        check({tag, ".pc_en1"}, 32'(hz1.pc_en), 32'(pc1));
    endtask

    task automatic idle();
        hz0.id_rs = 5'd0;  hz0.id_rt = 5'd0;  hz0.id_use_rs = 1'b0; hz0.id_use_rt = 1'b0;
        hz0.id_halt = 1'b0; hz0.ex_wsel = 5'd0; hz0.ex_regwr = 1'b0; hz0.ex_load = 1'b0;
        hz0.mem_wsel = 5'd0; hz0.mem_regwr = 1'b0; hz0.dmem_req = 1'b0; hz0.dhit = 1'b0;
        hz0.ihit = 1'b1; hz0.redirect = 1'b0; hz0.halt_wb = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        do_reset();

        // Reset state
        settle();
        ctl("rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        check("rst.fwd_a0", 32'(hz0.fwd_a), 32'd0);
        check("rst.fwd_b1", 32'(hz1.fwd_b), 32'd0);
        check("rst.halted0", 32'(hz0.halted), 32'd0);
        check("rst.stall_cnt0", 32'(hz0.stall_cnt), 32'd0);
        check("rst.flush_cnt1", 32'(hz1.flush_cnt), 32'd0);
        tick();

        // Icache miss in RUN: bubble into ID, PC held
        hz0.ihit = 1'b0;
        settle();
        ctl("imiss", 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b0);
        tick();
        hz0.ihit = 1'b1;

        // Forwarding predecode
        hz0.ex_regwr = 1'b1; hz0.ex_wsel = 5'd3; hz0.id_rt = 5'd3; hz0.id_use_rt = 1'b1;
        settle();
        ctl("fwd_ex", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();
        check("fwd_ex.fwd_b0", 32'(hz0.fwd_b), 32'd1);
        check("fwd_ex.fwd_b1", 32'(hz1.fwd_b), 32'd1);
        check("fwd_ex.fwd_a0", 32'(hz0.fwd_a), 32'd0);
        hz0.ex_wsel = 5'd0; hz0.id_rt = 5'd0;
        tick();
        check("fwd_r0.fwd_b0", 32'(hz0.fwd_b), 32'd0);
        hz0.ex_wsel = 5'd4; hz0.id_rs = 5'd4; hz0.mem_regwr = 1'b1; hz0.mem_wsel = 5'd4;
        tick();
        check("fwd_ex_over_mem.fwd_a0", 32'(hz0.fwd_a), 32'd1);
        hz0.ex_regwr = 1'b0;
        tick();
        check("fwd_mem.fwd_a0", 32'(hz0.fwd_a), 32'd2);

        // Load-use (with a same-cycle redirect that must lose)
        do_reset();
        hz0.ex_load = 1'b1; hz0.ex_regwr = 1'b1; hz0.ex_wsel = 5'd5;
        hz0.id_rs = 5'd5; hz0.id_use_rs = 1'b1; hz0.redirect = 1'b1;
        settle();
        ctl("lu1", 4'b1000, 4'b0100, 1'b0, 4'b1000, 4'b0100, 1'b0);
        tick();
        hz0.ex_load = 1'b0; hz0.ex_regwr = 1'b0; hz0.ex_wsel = 5'd0; hz0.redirect = 1'b0;
        hz0.mem_regwr = 1'b1; hz0.mem_wsel = 5'd5;
        settle();
        ctl("lu2", 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0100, 1'b0);
        tick();
        check("lu2.fwd_a0", 32'(hz0.fwd_a), 32'd2);
        check("lu2.fwd_a1", 32'(hz1.fwd_a), 32'd0);
        settle();
        ctl("lu3", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();
        check("lu3.fwd_a1", 32'(hz1.fwd_a), 32'd2);
        check("lu.stall_cnt0", 32'(hz0.stall_cnt), 32'd1);
        check("lu.stall_cnt1", 32'(hz1.stall_cnt), 32'd2);
        check("lu.flush_cnt1", 32'(hz1.flush_cnt), 32'd2);

        // Dcache miss for 4 cycles; redirect is ignored while held
        do_reset();
        hz0.dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hz0.redirect = (i == 1);
            settle();
            ctl($sformatf("miss%0d", i), 4'b1110, 4'b0001, 1'b0, 4'b1110, 4'b0001, 1'b0);
            tick();
        end
        hz0.redirect = 1'b0;
        hz0.dhit = 1'b1;
        settle();
        ctl("miss_exit", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();
        idle();
        check("miss.stall_cnt0", 32'(hz0.stall_cnt), 32'd4);
        check("miss.flush_cnt0", 32'(hz0.flush_cnt), 32'd4);
        check("miss.stall_cnt1", 32'(hz1.stall_cnt), 32'd4);

        // Redirect: EX-resolved flushes two latches, ID-resolved only one
        hz0.redirect = 1'b1;
        settle();
        ctl("redir", 4'b0000, 4'b1100, 1'b1, 4'b0000, 4'b1000, 1'b1);
        tick();
        idle();
        check("redir.flush_cnt0", 32'(hz0.flush_cnt), 32'd5);
        check("redir.flush_cnt1", 32'(hz1.flush_cnt), 32'd5);

        // Counter saturation, then reset in the middle of a miss
        do_reset();
        hz0.ex_regwr = 1'b1; hz0.ex_wsel = 5'd7; hz0.id_rs = 5'd7; hz0.id_use_rs = 1'b1;
        tick();
        check("pre_miss.fwd_a0", 32'(hz0.fwd_a), 32'd1);
        hz0.ex_regwr = 1'b0; hz0.dmem_req = 1'b1; hz0.dhit = 1'b0;
        repeat (20) tick();
        check("sat.stall_cnt0", 32'(hz0.stall_cnt), 32'd20);
        check("sat.stall_cnt1", 32'(hz1.stall_cnt), 32'd15);
        check("sat.flush_cnt1", 32'(hz1.flush_cnt), 32'd15);
        check("miss_hold.fwd_a0", 32'(hz0.fwd_a), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        idle();
        settle();
        ctl("rst_miss", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        check("rst_miss.stall_cnt0", 32'(hz0.stall_cnt), 32'd0);
        check("rst_miss.flush_cnt1", 32'(hz1.flush_cnt), 32'd0);
        check("rst_miss.fwd_a0", 32'(hz0.fwd_a), 32'd0);
        tick();

        // Halt drain then sticky halt
        hz0.id_halt = 1'b1;
        settle();
        ctl("halt_id", 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b0);
        tick();
        hz0.id_halt = 1'b0; hz0.redirect = 1'b1;
        settle();
        ctl("drain1", 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b0);
        tick();
        hz0.redirect = 1'b0;
        settle();
        ctl("drain2", 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b0);
        tick();
        hz0.halt_wb = 1'b1;
        settle();
        ctl("halt_wb", 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
        tick();
        hz0.halt_wb = 1'b0;
        check("halt.halted0", 32'(hz0.halted), 32'd1);
        check("halt.halted1", 32'(hz1.halted), 32'd1);
        settle();
        ctl("halted", 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
        tick();
        check("halt_sticky.halted0", 32'(hz0.halted), 32'd1);
        check("halt.flush_cnt0", 32'(hz0.flush_cnt), 32'd3);
        do_reset();
        settle();
        check("halt_rst.halted0", 32'(hz0.halted), 32'd0);
        ctl("halt_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
